// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default constants.
package fetch_pkg;

    // Fetch sequencer states: normal fetching, holding a fetched word while
    // decode is stalled, and waiting out a stale response after a redirect.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // Default first fetch address after reset.
    localparam logic [63:0] FETCH_RESET_VECTOR = 64'h0;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and imem.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   o_imem_req;
    logic [ADDR_WIDTH-1:0]  o_imem_addr;
    logic                   i_imem_valid;
    logic [INSTR_WIDTH-1:0] i_imem_rdata;

    // Fetch side issues requests and consumes responses.
    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_valid, i_imem_rdata
    );

    // Memory side accepts requests and returns responses.
    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_valid, i_imem_rdata
    );
endinterface

// File: rtl/preg_fetch.sv
// IF/ID pipeline register: flush zeroes it, stall holds it, otherwise it loads.
module preg_fetch #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   nxt_valid,
    input  logic [INSTR_WIDTH-1:0] nxt_instr,
    input  logic [ADDR_WIDTH-1:0]  nxt_pc,
    input  logic [ADDR_WIDTH-1:0]  nxt_pc_plus4,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [ADDR_WIDTH-1:0]  pc_plus4
);

    // Flush beats stall beats load; a flushed entry is all zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (!stall) begin
            valid    <= nxt_valid;
            instr    <= nxt_instr;
            pc       <= nxt_pc;
            pc_plus4 <= nxt_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling, stall buffering.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 64,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(FETCH_RESET_VECTOR)
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_fetch,
    input  logic                   i_flush_dec,
    input  logic                   i_branch_taken,
    input  logic [ADDR_WIDTH-1:0]  i_branch_target,
    fetch_stage_if.master          imem,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic                   o_valid
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d, tgt_q, tgt_d, pc_plus4;
    logic                   req, done;

    // One-entry buffer for a word that arrived while decode was stalled.
    logic                   hold_vld_q;
    logic [INSTR_WIDTH-1:0] hold_instr_q;
    logic [ADDR_WIDTH-1:0]  hold_pc_q, hold_pc4_q;
    logic                   hold_load, hold_drop;

    // Next IF/ID contents; all zero when no instruction is delivered.
    logic                   nxt_valid;
    logic [INSTR_WIDTH-1:0] nxt_instr;
    logic [ADDR_WIDTH-1:0]  nxt_pc, nxt_pc4;

    assign pc_plus4         = pc_q + ADDR_WIDTH'(4);
    assign req              = (state_q != ST_HOLD);
    assign done             = req & imem.i_imem_valid;
    assign imem.o_imem_req  = req;
    assign imem.o_imem_addr = pc_q;

    // Next-state, next-PC and IF/ID source selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        hold_load = 1'b0;
        hold_drop = 1'b0;
        nxt_valid = 1'b0;
        nxt_instr = '0;
        nxt_pc    = '0;
        nxt_pc4   = '0;
        case (state_q)
            ST_FETCH: begin
                if (i_branch_taken) begin
                    // Outstanding word is wrong-path; if it has not arrived
                    // yet, remember the target and wait for it to drain.
                    if (done) begin
                        pc_d = i_branch_target;
                    end else begin
                        tgt_d   = i_branch_target;
                        state_d = ST_DISCARD;
                    end
                end else if (done) begin
                    pc_d = pc_plus4;
                    if (i_stall_fetch) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        nxt_valid = 1'b1;
                        nxt_instr = imem.i_imem_rdata;
                        nxt_pc    = pc_q;
                        nxt_pc4   = pc_plus4;
                    end
                end
            end
            ST_HOLD: begin
                if (i_branch_taken) begin
                    hold_drop = 1'b1;
                    pc_d      = i_branch_target;
                    state_d   = ST_FETCH;
                end else if (!i_stall_fetch && hold_vld_q) begin
                    hold_drop = 1'b1;
                    nxt_valid = 1'b1;
                    nxt_instr = hold_instr_q;
                    nxt_pc    = hold_pc_q;
                    nxt_pc4   = hold_pc4_q;
                    state_d   = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // Latest redirect wins, even in the cycle the stale word lands.
                if (i_branch_taken) tgt_d = i_branch_target;
                if (done) begin
                    pc_d    = i_branch_taken ? i_branch_target : tgt_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Sequencer state, PC and pending redirect target.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Stall hold buffer; decode flushes leave it untouched.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            hold_vld_q   <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            hold_pc4_q   <= '0;
        end else if (hold_load) begin
            hold_vld_q   <= 1'b1;
            hold_instr_q <= imem.i_imem_rdata;
            hold_pc_q    <= pc_q;
            hold_pc4_q   <= pc_plus4;
        end else if (hold_drop) begin
            hold_vld_q   <= 1'b0;
        end
    end

    preg_fetch #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ifid (
        .clk          (i_clk),
        .rst          (i_arst),
        .flush        (i_flush_dec),
        .stall        (i_stall_fetch),
        .nxt_valid    (nxt_valid),
        .nxt_instr    (nxt_instr),
        .nxt_pc       (nxt_pc),
        .nxt_pc_plus4 (nxt_pc4),
        .valid        (o_valid),
        .instr        (o_instr),
        .pc           (o_pc),
        .pc_plus4     (o_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against a
// transaction-level model of the fetch rules.
module tb_fetch_stage;
    localparam int AW = 64;
    localparam int IW = 32;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    logic          i_clk = 1'b0;
    logic          i_arst, i_stall_fetch, i_flush_dec, i_branch_taken;
    logic [AW-1:0] i_branch_target;
    logic [IW-1:0] o_instr;
    logic [AW-1:0] o_pc, o_pc_plus4;
    logic          o_valid;

    fetch_stage_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem ();

    fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_VECTOR(64'h0)) dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_stall_fetch   (i_stall_fetch),
        .i_flush_dec     (i_flush_dec),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .imem            (imem),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_valid         (o_valid)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Model: next fetch address, pending-redirect bookkeeping, words parked
    // while decode stalls, and what decode should currently see.
    logic [AW-1:0] m_pc, m_target;
    logic          m_wrong_path;
    ent_t          m_held[$];
    logic          e_valid, e_zero;
    logic [IW-1:0] e_instr;
    logic [AW-1:0] e_pc;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = 64'h0;
        m_target     = 64'h0;
        m_wrong_path = 1'b0;
        m_held.delete();
        e_valid      = 1'b0;
        e_zero       = 1'b1;
        e_instr      = '0;
        e_pc         = '0;
    endtask

    task automatic check_outputs();
        chk1 ("imem_req",  imem.o_imem_req, m_held.size() == 0);
        chk64("imem_addr", imem.o_imem_addr, m_pc);
        chk1 ("ifid_valid", o_valid, e_valid);
        if (e_valid || e_zero) begin
            chk64("ifid_instr",    64'(o_instr), 64'(e_instr));
            chk64("ifid_pc",       o_pc, e_pc);
            chk64("ifid_pc_plus4", o_pc_plus4, e_valid ? e_pc + 64'd4 : 64'd0);
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic s, input logic f, input logic b,
                        input logic [AW-1:0] t, input logic v, input logic [IW-1:0] d);
        logic resp, dlv;
        ent_t ent;
        i_stall_fetch     = s;
        i_flush_dec       = f;
        i_branch_taken    = b;
        i_branch_target   = t;
        imem.i_imem_valid = v;
        imem.i_imem_rdata = d;
        resp = (m_held.size() == 0) && v;
        dlv  = 1'b0;
        ent  = '0;
        if (m_held.size() != 0) begin
            if (b) begin
                m_held.delete();
                m_pc = t;
            end else if (!s) begin
                ent = m_held.pop_front();
                dlv = 1'b1;
            end
        end else if (m_wrong_path) begin
            if (b) m_target = t;
            if (resp) begin
                m_pc         = b ? t : m_target;
                m_wrong_path = 1'b0;
            end
        end else if (b) begin
            if (resp) m_pc = t;
            else begin
                m_target     = t;
                m_wrong_path = 1'b1;
            end
        end else if (resp) begin
            ent.instr = d;
            ent.pc    = m_pc;
            if (s) m_held.push_back(ent);
            else   dlv = 1'b1;
            m_pc = m_pc + 64'd4;
        end
        if (f) begin
            e_valid = 1'b0;
            e_zero  = 1'b1;
            e_instr = '0;
            e_pc    = '0;
        end else if (!s) begin
            e_valid = dlv;
            e_zero  = 1'b0;
            e_instr = dlv ? ent.instr : '0;
            e_pc    = dlv ? ent.pc : '0;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs();
    endtask

    initial begin
        i_arst = 1'b1; i_stall_fetch = 1'b0; i_flush_dec = 1'b0;
        i_branch_taken = 1'b0; i_branch_target = '0;
        imem.i_imem_valid = 1'b0; imem.i_imem_rdata = '0;
        model_reset();
        repeat (2) @(negedge i_clk);
        check_outputs();
        i_arst = 1'b0;
        chk64("first_req_addr", imem.o_imem_addr, 64'h0);

        // Back-to-back fetches from reset.
        step(0, 0, 0, '0, 1, 32'h1111_0000);
        chk1 ("first_valid", o_valid, 1'b1);
        chk64("first_pc", o_pc, 64'h0);
        chk64("first_pc4", o_pc_plus4, 64'h4);
        chk64("req_addr_4", imem.o_imem_addr, 64'h4);
        step(0, 0, 0, '0, 1, 32'h1111_0004);
        chk64("req_addr_8", imem.o_imem_addr, 64'h8);

        // Word for 0x8 arrives under a 3-cycle stall.
        step(1, 0, 0, '0, 1, 32'h1111_0008);
        chk1("hold_req_0", imem.o_imem_req, 1'b0);
        step(1, 0, 0, '0, 1, 32'hBAD0_0001);
        chk1("hold_req_1", imem.o_imem_req, 1'b0);
        step(1, 0, 0, '0, 1, 32'hBAD0_0002);
        chk1("hold_req_2", imem.o_imem_req, 1'b0);
        step(0, 0, 0, '0, 0, '0);
        chk64("held_instr", 64'(o_instr), 64'h1111_0008);
        chk64("held_pc", o_pc, 64'h8);

        // Redirect to 0x100 while the 0xC fetch is outstanding.
        step(0, 0, 1, 64'h100, 0, '0);
        step(0, 0, 0, '0, 0, '0);
        step(0, 0, 0, '0, 1, 32'hDEAD_000C);
        chk1 ("stale_dropped", o_valid, 1'b0);
        chk64("redirect_addr", imem.o_imem_addr, 64'h100);

        // Redirects stacking up while a stale word is still pending.
        step(0, 0, 1, 64'h180, 0, '0);
        step(0, 0, 1, 64'h200, 0, '0);
        step(0, 0, 1, 64'h300, 0, '0);
        step(0, 0, 0, '0, 1, 32'hDEAD_0100);
        chk64("latest_redirect", imem.o_imem_addr, 64'h300);

        // Flush together with stall clears IF/ID.
        step(0, 0, 0, '0, 1, 32'h2222_0300);
        chk1("pre_flush_valid", o_valid, 1'b1);
        step(1, 1, 0, '0, 0, '0);
        chk1 ("flush_valid", o_valid, 1'b0);
        chk64("flush_instr", 64'(o_instr), 64'h0);
        chk64("flush_pc", o_pc, 64'h0);
        chk64("flush_pc4", o_pc_plus4, 64'h0);

        // PC wrap at the top of the address space.
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hDEAD_0304);
        step(0, 0, 0, '0, 1, 32'h3333_FFFC);
        chk64("wrap_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk64("wrap_pc4", o_pc_plus4, 64'h0);
        chk64("wrap_req_addr", imem.o_imem_addr, 64'h0);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            logic [AW-1:0] t;
            t = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, t, $urandom_range(0, 9) < 6, $urandom);
        end

        // Reset while a redirect is still waiting on a stale word.
        step(0, 0, 0, '0, 0, '0);
        step(0, 0, 1, 64'h500, 0, '0);
        i_stall_fetch = 1'b0; i_flush_dec = 1'b0; i_branch_taken = 1'b0;
        imem.i_imem_valid = 1'b0;
        i_arst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge i_clk);
        i_arst = 1'b0;
        chk64("post_rst_addr", imem.o_imem_addr, 64'h0);
        step(0, 0, 0, '0, 1, 32'h4444_0000);
        chk1 ("post_rst_valid", o_valid, 1'b1);
        chk64("post_rst_pc", o_pc, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the PC and memory address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, the instruction word width.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, the first fetch address after reset.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_arst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port i_stall_fetch, input, 1, hazard-unit hold of the IF/ID register.
REQ-007 SHALL have port i_flush_dec, input, 1, hazard-unit clear of the IF/ID register.
REQ-008 SHALL have ports i_branch_taken (input, 1) and i_branch_target (input, ADDR_WIDTH), the execute-stage redirect and its target.
REQ-009 SHALL have ports o_imem_req (output, 1) and o_imem_addr (output, ADDR_WIDTH), the instruction-memory request.
REQ-010 SHALL have ports i_imem_valid (input, 1) and i_imem_rdata (input, INSTR_WIDTH), the instruction-memory response.
REQ-011 SHALL have ports o_instr (INSTR_WIDTH), o_pc (ADDR_WIDTH), o_pc_plus4 (ADDR_WIDTH) and o_valid (1), all outputs, the IF/ID register contents fed to decode.

Function
REQ-012 SHALL hold a PC register pc_q, a one-entry hold buffer, a redirect-target register tgt_q, and a 3-state FSM: FETCH, HOLD, DISCARD.
REQ-013 SHALL drive o_imem_req=1 in FETCH and DISCARD and 0 in HOLD.
REQ-014 SHALL drive o_imem_addr=pc_q at all times, with pc_q held stable while a request is outstanding.
REQ-015 SHALL treat a request as complete in the cycle i_imem_valid=1 while o_imem_req=1; i_imem_valid SHALL be ignored while o_imem_req=0.
REQ-016 In FETCH, on valid, with no redirect and no stall: SHALL load IF/ID with {i_imem_rdata, pc_q, pc_q+4, valid=1}, set pc_q<=pc_q+4, and stay in FETCH.
REQ-017 In FETCH, on valid, with no redirect and stall=1: SHALL load the hold buffer with the same tuple, set pc_q<=pc_q+4, and go to HOLD.
REQ-018 In HOLD, with stall=0: SHALL move the hold buffer into IF/ID and go to FETCH.
REQ-019 In FETCH, with redirect and valid in the same cycle: SHALL discard the data, set pc_q<=i_branch_target, and stay in FETCH.
REQ-020 In FETCH, with redirect and no valid: SHALL set tgt_q<=i_branch_target and go to DISCARD.
REQ-021 In DISCARD: SHALL drop the response data, and on valid SHALL set pc_q<=tgt_q and go to FETCH.
REQ-022 A redirect arriving while in DISCARD SHALL overwrite tgt_q (the latest redirect wins); with valid in the same cycle, SHALL load pc_q directly from i_branch_target.
REQ-023 In HOLD, a redirect SHALL drop the hold buffer, set pc_q<=i_branch_target, and go to FETCH.
REQ-024 IF/ID update priority SHALL be: i_flush_dec (all outputs zero) > i_stall_fetch (hold) > load.
REQ-025 A flush SHALL NOT clear the hold buffer or change the FSM state.
REQ-026 pc_q+4 SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 The redirect target SHALL be used unmodified, with no alignment check.
REQ-028 Latency from memory valid to o_valid SHALL be exactly 1 cycle when not stalled.

Reset
REQ-029 While i_arst=1: SHALL set pc_q=RESET_VECTOR, tgt_q=0, hold buffer empty, FSM=FETCH, and o_instr, o_pc, o_pc_plus4 and o_valid all zero.
REQ-030 Reset asserted mid-request SHALL abandon the request; after release, the first request SHALL be issued to RESET_VECTOR.

Structure
REQ-031 SHALL place the FSM state enum (fetch_state_t) and the default RESET_VECTOR constant in shared package fetch_pkg.
REQ-032 SHALL implement the IF/ID register as sub-module preg_fetch, with reset, flush and stall, and zero-on-flush.

Verification
REQ-033 The bench SHALL cover: reset release, memory valid every cycle -> requests to 0x0, 0x4, 0x8; o_pc=0x0, o_pc_plus4=0x4, o_valid=1 one cycle after the first valid.
REQ-034 The bench SHALL cover: valid for 0x8 while stalled 3 cycles -> FSM in HOLD, o_imem_req=0 for those cycles; the 0x8 instruction appears on o_instr one cycle after stall drops.
REQ-035 The bench SHALL cover: redirect to 0x100 with the 0xC request outstanding and valid 2 cycles later -> 0xC data never reaches o_valid=1; the next request address is 0x100.
REQ-036 The bench SHALL cover: two redirects (0x200 then 0x300) during DISCARD -> the next fetch is 0x300.
REQ-037 The bench SHALL cover: flush and stall asserted together -> o_valid=0 with all IF/ID outputs 0.
REQ-038 The bench SHALL cover: pc_q=2^ADDR_WIDTH-4 -> o_pc_plus4=0 and the next request address is 0.
